// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the CPU-bus to 16-bit async SRAM bridge.
// Per-state SRAM control encoding lives here so the FSM only names target states.
package sram_bridge_pkg;

    localparam int unsigned SRAM_HADDR_W = 20;
    localparam int unsigned SRAM_DATA_W  = 16;
    localparam int unsigned WIN_CMP_W    = 11;

    typedef enum logic [2:0] {
        IDLE,
        LO_SETUP,
        LO_STROBE,
        HI_SETUP,
        HI_STROBE,
        DONE
    } state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic lb_n;
        logic ub_n;
        logic dq_oe;
    } sram_ctl_t;

    localparam sram_ctl_t CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                       lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

    // Control pins to present while the FSM sits in state st.
    function automatic sram_ctl_t ctl_for(input state_t st, input logic wr);
        sram_ctl_t c;
        c = CTL_IDLE;
        if (st == LO_SETUP || st == LO_STROBE || st == HI_SETUP || st == HI_STROBE) begin
            c.ce_n = 1'b0;
            c.lb_n = 1'b0;
            c.ub_n = 1'b0;
            if (wr) begin
                c.dq_oe = 1'b1;
                c.we_n  = !(st == LO_STROBE || st == HI_STROBE);
            end else begin
                c.oe_n = 1'b0;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sram_bridge.sv
// Splits 32-bit CPU bus accesses in a 2 MiB window into two 16-bit async SRAM cycles.
// Optional posted writes: define SRAM_BRIDGE_WRBUF_EN.
import sram_bridge_pkg::*;

module sram_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                    ACLK,
    input  logic                    RESET,
    input  logic [31:0]             ADDR,
    input  logic [31:0]             DATA_I,
    output logic [31:0]             DATA_O,
    input  logic                    WRSTB,
    input  logic                    RDSTB,
    output logic                    BUSY,
    output logic [SRAM_HADDR_W-1:0] SRAM_ADDR,
    input  logic [SRAM_DATA_W-1:0]  SRAM_DQ_I,
    output logic [SRAM_DATA_W-1:0]  SRAM_DQ_O,
    output logic                    SRAM_DQ_OE,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_OE_N,
    output logic                    SRAM_WE_N,
    output logic                    SRAM_LB_N,
    output logic                    SRAM_UB_N
);

    localparam logic [2:0] LP_WAIT = WAIT_CYCLES[2:0];

    state_t                   r_state;
    logic [2:0]               r_cnt;
    logic                     r_wr;
    logic [18:0]              r_addr;
    logic [SRAM_DATA_W-1:0]   r_wdata_hi;
    logic [31:0]              r_rdata;
    sram_ctl_t                r_ctl;
    logic [SRAM_HADDR_W-1:0]  r_sram_addr;
    logic [SRAM_DATA_W-1:0]   r_dq_o;

    logic                     w_hit;
    logic                     w_busy;

    assign w_hit = (RDSTB || WRSTB) &&
                   (ADDR[31 -: WIN_CMP_W] == BASE_ADDR[31 -: WIN_CMP_W]);

`ifdef SRAM_BRIDGE_WRBUF_EN
    // A write hit in IDLE is posted; anything arriving behind a posted write waits for IDLE.
    always_comb begin
        w_busy = 1'b0;
        if (w_hit) begin
            if (r_state == IDLE)
                w_busy = !WRSTB;
            else
                w_busy = r_wr || (r_state != DONE);
        end
    end
`else
    assign w_busy = w_hit && (r_state != DONE);
`endif

    assign BUSY   = w_busy;
    assign DATA_O = (w_hit && r_state == DONE && !r_wr) ? r_rdata : '0;

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata_hi  <= '0;
            r_rdata     <= '0;
            r_ctl       <= CTL_IDLE;
            r_sram_addr <= '0;
            r_dq_o      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state     <= LO_SETUP;
                        r_wr        <= WRSTB;
                        r_addr      <= ADDR[20:2];
                        r_wdata_hi  <= DATA_I[31:16];
                        r_ctl       <= ctl_for(LO_SETUP, WRSTB);
                        r_sram_addr <= {ADDR[20:2], 1'b0};
                        r_dq_o      <= DATA_I[15:0];
                        r_cnt       <= '0;
                    end
                end
                LO_SETUP: begin
                    r_state <= LO_STROBE;
                    r_ctl   <= ctl_for(LO_STROBE, r_wr);
                    r_cnt   <= '0;
                end
                LO_STROBE: begin
                    if (r_cnt == LP_WAIT) begin
                        if (!r_wr)
                            r_rdata[15:0] <= SRAM_DQ_I;
                        r_state     <= HI_SETUP;
                        r_ctl       <= ctl_for(HI_SETUP, r_wr);
                        r_sram_addr <= {r_addr, 1'b1};
                        r_dq_o      <= r_wdata_hi;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                HI_SETUP: begin
                    r_state <= HI_STROBE;
                    r_ctl   <= ctl_for(HI_STROBE, r_wr);
                    r_cnt   <= '0;
                end
                HI_STROBE: begin
                    if (r_cnt == LP_WAIT) begin
                        if (!r_wr)
                            r_rdata[31:16] <= SRAM_DQ_I;
                        r_state <= DONE;
                        r_ctl   <= CTL_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ctl   <= CTL_IDLE;
                end
            endcase
        end
    end

    assign SRAM_ADDR  = r_sram_addr;
    assign SRAM_DQ_O  = r_dq_o;
    assign SRAM_DQ_OE = r_ctl.dq_oe;
    assign SRAM_CE_N  = r_ctl.ce_n;
    assign SRAM_OE_N  = r_ctl.oe_n;
    assign SRAM_WE_N  = r_ctl.we_n;
    assign SRAM_LB_N  = r_ctl.lb_n;
    assign SRAM_UB_N  = r_ctl.ub_n;

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: behavioural SRAM, word-level reference memory,
// directed steps followed by randomized CPU accesses.
module tb_sram_bridge;

    logic        ACLK = 1'b0;
    logic        RESET;
    logic [31:0] ADDR;
    logic [31:0] DATA_I;
    logic [31:0] DATA_O;
    logic        WRSTB;
    logic        RDSTB;
    logic        BUSY;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_I;
    logic [15:0] SRAM_DQ_O;
    logic        SRAM_DQ_OE;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SRAM_BRIDGE_WRBUF_EN
    localparam int WR_BUSY = 0;
`else
    localparam int WR_BUSY = 7;
`endif
    localparam int RD_BUSY = 7;

    sram_bridge #(.BASE_ADDR(32'h0020_0000), .WAIT_CYCLES(1)) dut (
        .ACLK(ACLK), .RESET(RESET), .ADDR(ADDR), .DATA_I(DATA_I), .DATA_O(DATA_O),
        .WRSTB(WRSTB), .RDSTB(RDSTB), .BUSY(BUSY),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_I(SRAM_DQ_I), .SRAM_DQ_O(SRAM_DQ_O),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural async SRAM and write-pulse log
    logic [15:0] sram_mem [logic [19:0]];
    logic [19:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_len_q  [$];
    logic        we_prev = 1'b1;
    int          pulse_len = 0;
    logic [19:0] pulse_addr;
    logic [15:0] pulse_data;

    initial SRAM_DQ_I = '0;

    always @(negedge ACLK) begin
        if (SRAM_WE_N === 1'b0) begin
            chk("we_needs_dq_oe", {31'b0, SRAM_DQ_OE}, 32'd1);
            chk("we_with_oe_n",   {31'b0, SRAM_OE_N},  32'd1);
            chk("we_with_ce_n",   {31'b0, SRAM_CE_N},  32'd0);
            if (we_prev !== 1'b0) pulse_len = 0;
            pulse_len++;
            pulse_addr = SRAM_ADDR;
            pulse_data = SRAM_DQ_O;
            sram_mem[SRAM_ADDR] = SRAM_DQ_O;
        end else if (we_prev === 1'b0) begin
            wr_addr_q.push_back(pulse_addr);
            wr_data_q.push_back(pulse_data);
            wr_len_q.push_back(pulse_len);
        end
        we_prev = SRAM_WE_N;
        if (SRAM_OE_N === 1'b0 && SRAM_CE_N === 1'b0)
            SRAM_DQ_I = sram_mem.exists(SRAM_ADDR) ? sram_mem[SRAM_ADDR] : 16'h0000;
        else
            SRAM_DQ_I = 16'hA5C3;
    end

    // Word-level reference: what the CPU should read back from each word address
    logic [31:0] ref_mem [logic [18:0]];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[20:2]) ? ref_mem[a[20:2]] : 32'h0;
    endfunction

    task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, output int busy_n,
                              output logic [31:0] rdata);
        @(negedge ACLK);
        ADDR = a; DATA_I = d; RDSTB = rd; WRSTB = wr;
        #1;
        busy_n = 0;
        while (BUSY === 1'b1 && busy_n < 40) begin
            chk("data_o_while_busy", DATA_O, 32'h0);
            busy_n++;
            @(negedge ACLK); #1;
        end
        rdata = DATA_O;
    endtask

    task automatic bus_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge ACLK);
            RDSTB = 1'b0; WRSTB = 1'b0;
            #1;
            chk("idle_busy",   {31'b0, BUSY}, 32'd0);
            chk("idle_data_o", DATA_O,        32'h0);
        end
    endtask

    logic [31:0] addr_tab [8];

    initial begin
        int          busy_n;
        logic [31:0] rdata, a, d;
        int          kind, gap;

        addr_tab[0] = 32'h0020_0000; addr_tab[1] = 32'h0020_0004;
        addr_tab[2] = 32'h0020_0010; addr_tab[3] = 32'h0020_0ABC;
        addr_tab[4] = 32'h002F_FFF8; addr_tab[5] = 32'h0030_0000;
        addr_tab[6] = 32'h003F_FFF8; addr_tab[7] = 32'h003F_FFFC;

        RESET = 1'b1; ADDR = '0; DATA_I = '0; WRSTB = 1'b0; RDSTB = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_busy",   {31'b0, BUSY},       32'd0);
        chk("rst_data_o", DATA_O,              32'h0);
        chk("rst_ctl_n",  {27'b0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
        chk("rst_dq_oe",  {31'b0, SRAM_DQ_OE}, 32'd0);
        chk("rst_addr",   {12'b0, SRAM_ADDR},  32'h0);
        chk("rst_dq_o",   {16'b0, SRAM_DQ_O},  32'h0);
        RESET = 1'b0;
        bus_idle(2);

        // Directed write: low half first, 2-cycle WE pulses
        cpu_access(1'b0, 1'b1, 32'h0020_0010, 32'hDEAD_BEEF, busy_n, rdata);
        ref_mem[19'h4] = 32'hDEAD_BEEF;
        chk("wr_busy_cycles", 32'(busy_n), 32'(WR_BUSY));
        chk("wr_done_data_o", rdata, 32'h0);
        bus_idle(10);
        chk("wr_pulse_count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            chk("wr_lo_addr", {12'b0, wr_addr_q[0]}, 32'h00008);
            chk("wr_lo_data", {16'b0, wr_data_q[0]}, 32'h0000BEEF);
            chk("wr_lo_len",  32'(wr_len_q[0]),      32'd2);
            chk("wr_hi_addr", {12'b0, wr_addr_q[1]}, 32'h00009);
            chk("wr_hi_data", {16'b0, wr_data_q[1]}, 32'h0000DEAD);
            chk("wr_hi_len",  32'(wr_len_q[1]),      32'd2);
        end
        wr_addr_q.delete(); wr_data_q.delete(); wr_len_q.delete();

        // Directed read-back
        cpu_access(1'b1, 1'b0, 32'h0020_0010, 32'h0, busy_n, rdata);
        chk("rd_busy_cycles", 32'(busy_n), 32'(RD_BUSY));
        chk("rd_data",        rdata,       32'hDEAD_BEEF);
        bus_idle(1);

        // Directed miss
        cpu_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, busy_n, rdata);
        chk("miss_busy", 32'(busy_n), 32'd0);
        chk("miss_data", rdata,       32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK); #1;
            chk("miss_busy_hold", {31'b0, BUSY},      32'd0);
            chk("miss_data_hold", DATA_O,             32'h0);
            chk("miss_ce_n",      {31'b0, SRAM_CE_N}, 32'd1);
            chk("miss_oe_n",      {31'b0, SRAM_OE_N}, 32'd1);
        end
        bus_idle(1);

        // Reset during HI_STROBE of a write
        @(negedge ACLK);
        ADDR = 32'h0020_0100; DATA_I = 32'h1234_5678; WRSTB = 1'b1; RDSTB = 1'b0;
        repeat (5) @(negedge ACLK);
        #1;
        chk("mid_hi_we_n", {31'b0, SRAM_WE_N}, 32'd0);
        chk("mid_hi_addr", {12'b0, SRAM_ADDR}, 32'h00081);
        RESET = 1'b1; WRSTB = 1'b0;
        @(negedge ACLK); #1;
        chk("mid_rst_we_n",  {31'b0, SRAM_WE_N},  32'd1);
        chk("mid_rst_dq_oe", {31'b0, SRAM_DQ_OE}, 32'd0);
        chk("mid_rst_ce_n",  {31'b0, SRAM_CE_N},  32'd1);
        chk("mid_rst_addr",  {12'b0, SRAM_ADDR},  32'h0);
        RESET = 1'b0;
        bus_idle(1);
        wr_addr_q.delete(); wr_data_q.delete(); wr_len_q.delete();
        cpu_access(1'b1, 1'b0, 32'h0020_0010, 32'h0, busy_n, rdata);
        chk("post_rst_busy", 32'(busy_n), 32'(RD_BUSY));
        chk("post_rst_data", rdata,       32'hDEAD_BEEF);
        bus_idle(1);

`ifdef SRAM_BRIDGE_WRBUF_EN
        // Posted write followed immediately by a read of the same word
        d = $urandom;
        cpu_access(1'b0, 1'b1, 32'h0020_0014, d, busy_n, rdata);
        ref_mem[19'h5] = d;
        chk("post_wr_busy", 32'(busy_n), 32'd0);
        cpu_access(1'b1, 1'b0, 32'h0020_0014, 32'h0, busy_n, rdata);
        chk("post_rd_busy", 32'(busy_n), 32'd14);
        chk("post_rd_data", rdata,       d);
        bus_idle(1);
`endif

        // Randomized traffic, gap 0 gives back-to-back accesses
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = addr_tab[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            d    = $urandom;
            gap  = int'($urandom_range(0, 2));
            if (kind < 4) begin
                cpu_access(kind == 0, 1'b1, a, d, busy_n, rdata);
                ref_mem[a[20:2]] = d;
                chk("rnd_wr_busy", 32'(busy_n), 32'(WR_BUSY));
                chk("rnd_wr_data", rdata,       32'h0);
`ifdef SRAM_BRIDGE_WRBUF_EN
                gap = 9;
`endif
            end else if (kind < 8) begin
                cpu_access(1'b1, 1'b0, a, 32'h0, busy_n, rdata);
                chk("rnd_rd_busy", 32'(busy_n), 32'(RD_BUSY));
                chk("rnd_rd_data", rdata,       ref_read(a));
            end else begin
                a = a ^ (32'h1 << $urandom_range(21, 31));
                cpu_access(kind == 8, kind == 9, a, d, busy_n, rdata);
                chk("rnd_miss_busy", 32'(busy_n), 32'd0);
                chk("rnd_miss_data", rdata,       32'h0);
                @(negedge ACLK); #1;
                chk("rnd_miss_ce_n", {31'b0, SRAM_CE_N}, 32'd1);
            end
            bus_idle(gap);
        end

        // Read every table word back once more
        for (int j = 0; j < 8; j++) begin
            cpu_access(1'b1, 1'b0, addr_tab[j], 32'h0, busy_n, rdata);
            chk("final_rd_data", rdata, ref_read(addr_tab[j]));
        end
        bus_idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Bus responder that maps a 2 MiB window of the CPU's strobe-based memory bus onto the board's external 16-bit asynchronous SRAM. It sits beside the data memory and GPIO responders on the shared CPU bus and splits each 32-bit word access into two 16-bit SRAM cycles. While an access is in progress it raises a stall (BUSY) to the CPU.

## Interface
Parameters:
- BASE_ADDR, 32'h0020_0000, window base; bits [20:0] must be zero.
- WAIT_CYCLES, 1, extra SRAM strobe cycles per half-word (0..7).

Ports:
- ACLK  in  1  the only clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  32  CPU byte address; ADDR[1:0] ignored.
- DATA_I  in  32  CPU write data.
- DATA_O  out  32  read data; 0 unless this block is returning read data (OR-able shared bus).
- WRSTB  in  1  write strobe; held by the CPU while BUSY=1.
- RDSTB  in  1  read strobe; held by the CPU while BUSY=1.
- BUSY  out  1  CPU stall request; combinational.
- SRAM_ADDR  out  20  half-word address.
- SRAM_DQ_I  in  16  SRAM data in (the tri-state buffer lives at top level).
- SRAM_DQ_O  out  16  SRAM write data.
- SRAM_DQ_OE  out  1  drive enable for SRAM_DQ.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low SRAM controls.

## Operation
- Hit = (RDSTB|WRSTB) & (ADDR[31:21]==BASE_ADDR[31:21]). Misses are ignored entirely.
- If both strobes are set, the write wins.
- FSM states: IDLE, LO_SETUP, LO_STROBE, HI_SETUP, HI_STROBE, DONE.
  - IDLE -> LO_SETUP on a hit.
  - Each SETUP state lasts 1 cycle.
  - Each STROBE state lasts WAIT_CYCLES+1 cycles, counted by a 3-bit counter.
  - LO_STROBE -> HI_SETUP; HI_STROBE -> DONE; DONE -> IDLE.
- The access is latched at IDLE->LO_SETUP: ADDR[20:2], DATA_I, and the read/write flag. The strobes are not re-sampled after that.
- SRAM_ADDR = {addr[20:2], 1'b0} in the LO states and {addr[20:2], 1'b1} in the HI states. The low half-word holds DATA[15:0] (little-endian).
- All SRAM control and data outputs come from flops.
  - CE_N, LB_N and UB_N are low in all SETUP and STROBE states.
  - Writes: WE_N is low in STROBE states. DQ_OE is high in SETUP and STROBE states, with SRAM_DQ_O set to the current half.
  - Reads: OE_N is low in SETUP and STROBE states. SRAM_DQ_I is captured on the last STROBE cycle of each half.
- BUSY = hit & (state != DONE). It is 0 whenever there is no hit.
- DATA_O = the assembled 32-bit read word in DONE for a read; 0 otherwise.
- If the CPU drops its strobe mid-transaction, the SRAM access still completes (a WE pulse is never truncated). DONE is still visited, and the read data is discarded.
- A new hit seen in DONE is not accepted until IDLE, one cycle later.

## Timing
- Reset values: BUSY=0, DATA_O=0, SRAM_ADDR=0, SRAM_DQ_O=0, SRAM_DQ_OE=0, all SRAM_*_N=1, FSM in IDLE.
- RESET mid-transaction: FSM goes to IDLE at the next edge and all SRAM controls return to their reset values. A partial write may leave the SRAM half-updated; this is accepted.
- Latency: strobe cycle 0 (IDLE, BUSY=1) -> DONE at cycle 2*(WAIT_CYCLES+2)+1.
  - WAIT_CYCLES=1: BUSY is high for cycles 0..6; DONE (BUSY=0, read data valid) is cycle 7.
- Back-to-back accesses: a second hit takes the IDLE->LO_SETUP transition on the cycle after DONE.

## Configuration
- SRAM_BRIDGE_WRBUF_EN: posted writes.
  - Defined: a write hit in IDLE is latched with BUSY=0, and the CPU proceeds at the next cycle while the SRAM write runs in the background. Any hit that arrives while the posted write is in flight sees BUSY=1 until the FSM is back in IDLE; it is then serviced normally.
  - Undefined: writes stall like reads, as described above.

## Structure
- Package sram_bridge_pkg holds:
  - the state enum type;
  - the SRAM_HADDR_W=20 and SRAM_DATA_W=16 constants;
  - the window compare width constant (11 bits).
- There is no sub-module: the FSM and the counter form a single module. The top level owns the SRAM_DQ tri-state (SRAM_DQ = SRAM_DQ_OE ? SRAM_DQ_O : 'z).

## Test plan
- Reset: hold RESET for 3 cycles -> all SRAM_*_N=1, DQ_OE=0, BUSY=0, DATA_O=0.
- Write 0xDEADBEEF to 0x0020_0010 (WAIT_CYCLES=1) -> SRAM write at 0x00008 with 0xBEEF, then at 0x00009 with 0xDEAD. Each WE_N low pulse lasts 2 cycles; BUSY is high for exactly 7 cycles.
- Read back 0x0020_0010 -> DATA_O=0xDEADBEEF only in the DONE cycle, and 0 in every other cycle.
- Read 0x0000_0010 (outside the window) -> BUSY=0, DATA_O=0, SRAM controls idle.
- Assert RESET during HI_STROBE of a write -> next cycle FSM in IDLE, WE_N=1, DQ_OE=0.
- With SRAM_BRIDGE_WRBUF_EN: write then immediate read to the same address -> write BUSY=0, read stalls until the write finishes, then returns the written data.
